// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types, constants and index helpers for the Autolife
//                4x4 toroidal Game-of-Life cell array.
//  Contents    : CELL_IDX_W, GRID_W, CELL_LAST, cell_idx_t, op_e,
//                row_of(), col_of()
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    localparam int CELL_IDX_W = 4;
    localparam int GRID_W     = 16;

    typedef logic [CELL_IDX_W-1:0] cell_idx_t;

    localparam cell_idx_t CELL_LAST = cell_idx_t'(GRID_W - 1);

    // Decoded per-cycle operation after strobe prioritisation.
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_RESTART = 3'd1,
        OP_LOAD    = 3'd2,
        OP_READ    = 3'd3,
        OP_WRITE   = 3'd4
    } op_e;

    function automatic logic [1:0] row_of(input cell_idx_t idx);
        return idx[3:2];
    endfunction

    function automatic logic [1:0] col_of(input cell_idx_t idx);
        return idx[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_neighbor_sum.sv
`default_nettype none
// ============================================================================
//  Module      : life_neighbor_sum
//  Description : Combinational count of live neighbours of one cell on the
//                4x4 torus. Row/column offsets use 2-bit wrap-around.
//  Ports       : i_grid [15:0] - cell array, bit i = row i[3:2], col i[1:0]
//                i_idx  [3:0]  - cell being evaluated
//                o_sum  [3:0]  - live neighbour count, 0..8
//  Revision    : 1.0 - initial release
// ============================================================================
module life_neighbor_sum
    import life_pkg::*;
(
    input  logic [GRID_W-1:0] i_grid,
    input  cell_idx_t         i_idx,
    output logic [3:0]        o_sum
);

    logic [1:0] w_r;
    logic [1:0] w_c;
    logic [1:0] w_rm;
    logic [1:0] w_rp;
    logic [1:0] w_cm;
    logic [1:0] w_cp;

    // One cell zero-extended so eight of them sum without overflow.
    function automatic logic [3:0] cell_at(input logic [GRID_W-1:0] g,
                                           input logic [1:0]        r,
                                           input logic [1:0]        c);
        return {3'b000, g[{r, c}]};
    endfunction

    assign w_r  = row_of(i_idx);
    assign w_c  = col_of(i_idx);
    // 2-bit arithmetic wraps naturally: row 0 - 1 -> row 3.
    assign w_rm = w_r - 2'd1;
    assign w_rp = w_r + 2'd1;
    assign w_cm = w_c - 2'd1;
    assign w_cp = w_c + 2'd1;

    assign o_sum = cell_at(i_grid, w_rm, w_cm) + cell_at(i_grid, w_rm, w_c)
                 + cell_at(i_grid, w_rm, w_cp) + cell_at(i_grid, w_r,  w_cm)
                 + cell_at(i_grid, w_r,  w_cp) + cell_at(i_grid, w_rp, w_cm)
                 + cell_at(i_grid, w_rp, w_c)  + cell_at(i_grid, w_rp, w_cp);

endmodule
`default_nettype wire

// File: rtl/life_grid_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_grid_engine
//  Description : 4x4 toroidal Game-of-Life cell array. Serially loads a
//                pattern, scans one cell per cycle into a next-generation
//                buffer, and commits it on writeout. Reports extinction via
//                a sticky lose flag.
//  Ports       : clka       - system clock, rising edge
//                reset      - asynchronous, active-low
//                restart    - synchronous clear
//                loadData   - load one cell per cycle from load_bit
//                readData   - evaluate one cell per cycle
//                writeout   - commit next generation
//                load_bit   - serial cell value
//                grid       - current generation
//                loseSig    - sticky lose flag
//                gen_count  - committed generations, saturating
//                scan_done  - all 16 next-generation cells evaluated
//                commit_err - sticky: writeout seen before scan_done
//  Config      : LIFE_STAGNATION_LOSE_EN - still-life commits also set loseSig
//  Revision    : 1.0 - initial release
// ============================================================================
module life_grid_engine
    import life_pkg::*;
#(
    parameter int CELLS = 16,
    parameter int GEN_W = 8
) (
    input  logic             clka,
    input  logic             reset,
    input  logic             restart,
    input  logic             loadData,
    input  logic             readData,
    input  logic             writeout,
    input  logic             load_bit,
    output logic [CELLS-1:0] grid,
    output logic             loseSig,
    output logic [GEN_W-1:0] gen_count,
    output logic             scan_done,
    output logic             commit_err
);

    logic [GRID_W-1:0] cur_grid_q, cur_grid_d;
    logic [GRID_W-1:0] nxt_grid_q, nxt_grid_d;
    cell_idx_t         idx_q, idx_d;
    logic              scan_done_q, scan_done_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic              lose_q, lose_d;
    logic              commit_err_q, commit_err_d;

    op_e               w_op;
    logic [3:0]        w_sum;
    logic              w_next_cell;
    logic              w_lose_hit;

    life_neighbor_sum u_nsum (
        .i_grid (cur_grid_q),
        .i_idx  (idx_q),
        .o_sum  (w_sum)
    );

    assign w_next_cell = (w_sum == 4'd3) | (cur_grid_q[idx_q] & (w_sum == 4'd2));

`ifdef LIFE_STAGNATION_LOSE_EN
    assign w_lose_hit = (nxt_grid_q == '0) | (nxt_grid_q == cur_grid_q);
`else
    assign w_lose_hit = (nxt_grid_q == '0);
`endif

    // Strobe priority: restart > loadData > readData > writeout > idle.
    always_comb begin
        w_op = OP_IDLE;
        if (restart)       w_op = OP_RESTART;
        else if (loadData) w_op = OP_LOAD;
        else if (readData) w_op = OP_READ;
        else if (writeout) w_op = OP_WRITE;
    end

    always_comb begin
        cur_grid_d   = cur_grid_q;
        nxt_grid_d   = nxt_grid_q;
        idx_d        = idx_q;
        scan_done_d  = scan_done_q;
        gen_count_d  = gen_count_q;
        lose_d       = lose_q;
        commit_err_d = commit_err_q;

        case (w_op)
            OP_RESTART: begin
                cur_grid_d   = '0;
                nxt_grid_d   = '0;
                idx_d        = '0;
                scan_done_d  = 1'b0;
                gen_count_d  = '0;
                lose_d       = 1'b0;
                commit_err_d = 1'b0;
            end
            OP_LOAD: begin
                cur_grid_d[idx_q] = load_bit;
                idx_d             = idx_q + 4'd1;
                scan_done_d       = 1'b0;
            end
            OP_READ: begin
                nxt_grid_d[idx_q] = w_next_cell;
                idx_d             = idx_q + 4'd1;
                // A scan held past 16 cycles keeps scan_done set.
                if (idx_q == CELL_LAST) scan_done_d = 1'b1;
            end
            OP_WRITE: begin
                if (scan_done_q) begin
                    cur_grid_d  = nxt_grid_q;
                    scan_done_d = 1'b0;
                    if (gen_count_q != '1) gen_count_d = gen_count_q + GEN_W'(1);
                    if (w_lose_hit) lose_d = 1'b1;
                end else begin
                    commit_err_d = 1'b1;
                end
            end
            default: begin
                // Idle restarts any interrupted scan or load at cell 0.
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            cur_grid_q   <= '0;
            nxt_grid_q   <= '0;
            idx_q        <= '0;
            scan_done_q  <= 1'b0;
            gen_count_q  <= '0;
            lose_q       <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            cur_grid_q   <= cur_grid_d;
            nxt_grid_q   <= nxt_grid_d;
            idx_q        <= idx_d;
            scan_done_q  <= scan_done_d;
            gen_count_q  <= gen_count_d;
            lose_q       <= lose_d;
            commit_err_q <= commit_err_d;
        end
    end

    assign grid       = cur_grid_q;
    assign loseSig    = lose_q;
    assign gen_count  = gen_count_q;
    assign scan_done  = scan_done_q;
    assign commit_err = commit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_life_grid_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_grid_engine
//  Description : Self-checking bench for life_grid_engine. Table of
//                load/scan/commit steps with hand-computed results, plus
//                directed sequences for scan_done timing, async reset
//                mid-scan, simultaneous load/read strobes and generation
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_grid_engine;

    logic        clka;
    logic        reset;
    logic        restart;
    logic        loadData;
    logic        readData;
    logic        writeout;
    logic        load_bit;
    logic [15:0] grid;
    logic        loseSig;
    logic [7:0]  gen_count;
    logic        scan_done;
    logic        commit_err;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef LIFE_STAGNATION_LOSE_EN
    localparam bit BLOCK_LOSE = 1'b1;
`else
    localparam bit BLOCK_LOSE = 1'b0;
`endif

    life_grid_engine #(.CELLS(16), .GEN_W(8)) dut (
        .clka       (clka),
        .reset      (reset),
        .restart    (restart),
        .loadData   (loadData),
        .readData   (readData),
        .writeout   (writeout),
        .load_bit   (load_bit),
        .grid       (grid),
        .loseSig    (loseSig),
        .gen_count  (gen_count),
        .scan_done  (scan_done),
        .commit_err (commit_err)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    typedef struct {
        bit          rst_first;
        bit          do_load;
        logic [15:0] pat;
        int          n_reads;
        bit          do_write;
        logic [15:0] e_grid;
        logic [7:0]  e_gen;
        bit          e_lose;
        bit          e_err;
        bit          e_done;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [15:0] eg, input logic [7:0] egen,
                             input bit el, input bit ee, input bit ed);
        check({tag, ".grid"},       grid,              eg);
        check({tag, ".gen_count"},  {8'h00, gen_count}, {8'h00, egen});
        check({tag, ".loseSig"},    {15'h0, loseSig},    {15'h0, el});
        check({tag, ".commit_err"}, {15'h0, commit_err}, {15'h0, ee});
        check({tag, ".scan_done"},  {15'h0, scan_done},  {15'h0, ed});
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic idle();
        restart = 0; loadData = 0; readData = 0; writeout = 0; load_bit = 0;
        tick();
    endtask

    task automatic do_restart();
        restart = 1;
        tick();
        restart = 0;
    endtask

    task automatic load_pat(input logic [15:0] p);
        for (int i = 0; i < 16; i++) begin
            loadData = 1;
            load_bit = p[i];
            tick();
        end
        loadData = 0;
        load_bit = 0;
    endtask

    task automatic scan(input int n);
        readData = 1;
        repeat (n) tick();
        readData = 0;
    endtask

    task automatic commit();
        writeout = 1;
        tick();
        writeout = 0;
    endtask

    initial begin
        restart = 0; loadData = 0; readData = 0; writeout = 0; load_bit = 0;
        reset = 1;
        #1 reset = 0;
        #2;
        check_all("reset", 16'h0000, 8'd0, 0, 0, 0);
        @(negedge clka);
        @(negedge clka);
        reset = 1;

        //               rst load pat       rd  wr  e_grid    gen  lose        err done
        vecs[0] = '{1'b1, 1'b1, 16'h0070, 16, 1'b1, 16'h0222, 8'd1, 1'b0,       1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 16, 1'b1, 16'h0070, 8'd2, 1'b0,       1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0001, 16, 1'b1, 16'h0000, 8'd1, 1'b1,       1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 0,  1'b0, 16'h0000, 8'd0, 1'b0,       1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h0033, 16, 1'b1, 16'h0033, 8'd1, BLOCK_LOSE, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h0070, 7,  1'b1, 16'h0070, 8'd0, 1'b0,       1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 16'h0070, 16, 1'b0, 16'h0070, 8'd0, 1'b0,       1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 0,  1'b1, 16'h0222, 8'd1, 1'b0,       1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'hFFFF, 16, 1'b1, 16'h0000, 8'd1, 1'b1,       1'b0, 1'b0};

        for (int v = 0; v < NV; v++) begin
            idle();
            if (vecs[v].rst_first) do_restart();
            if (vecs[v].do_load) load_pat(vecs[v].pat);
            if (vecs[v].n_reads > 0) scan(vecs[v].n_reads);
            if (vecs[v].do_write) commit();
            check_all($sformatf("vec%0d", v), vecs[v].e_grid, vecs[v].e_gen,
                      vecs[v].e_lose, vecs[v].e_err, vecs[v].e_done);
        end

        // scan_done rises only after the 16th readData edge.
        idle();
        do_restart();
        load_pat(16'h0070);
        check("load.grid", grid, 16'h0070);
        scan(15);
        check("scan15.done", {15'h0, scan_done}, 16'h0000);
        scan(1);
        check("scan16.done", {15'h0, scan_done}, 16'h0001);
        // Holding readData past 16 cycles keeps scan_done set.
        scan(3);
        check("scan19.done", {15'h0, scan_done}, 16'h0001);

        // Async reset mid-scan clears everything, then a fresh run works.
        idle();
        do_restart();
        load_pat(16'h0070);
        scan(16);
        commit();
        commit();
        check_all("pre_rst", 16'h0222, 8'd1, 0, 1, 0);
        idle();
        load_pat(16'h0070);
        readData = 1;
        repeat (9) tick();
        #2 reset = 0;
        #1;
        check_all("rst_mid", 16'h0000, 8'd0, 0, 0, 0);
        @(negedge clka);
        readData = 0;
        reset = 1;
        idle();
        load_pat(16'h0070);
        scan(16);
        commit();
        check_all("post_rst", 16'h0222, 8'd1, 0, 0, 0);

        // loadData and readData together behave as a load and clear scan_done.
        idle();
        load_pat(16'h0070);
        scan(16);
        check("pre_both.done", {15'h0, scan_done}, 16'h0001);
        readData = 1;
        for (int i = 0; i < 16; i++) begin
            loadData = 1;
            load_bit = (i == 0);
            tick();
        end
        loadData = 0; readData = 0; load_bit = 0;
        check("both.grid", grid, 16'h0001);
        check("both.done", {15'h0, scan_done}, 16'h0000);

        // Generation counter saturates at all-ones.
        idle();
        do_restart();
        load_pat(16'h0033);
        for (int g = 0; g < 256; g++) begin
            scan(16);
            commit();
            idle();
        end
        check("sat.gen_count", {8'h00, gen_count}, 16'h00FF);
        check("sat.grid", grid, 16'h0033);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
